// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential non-restoring divider.
//   divState_t : FSM state encoding (IDLE, ITER, FIX, SIGN, DONE)
//   clog2      : counter width helper, never returns less than 1
package div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ITER = 3'd1,
    FIX  = 3'd2,
    SIGN = 3'd3,
    DONE = 3'd4
  } divState_t;

  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/nr_div_step.sv
// Combinational W-bit add/subtract step of the non-restoring divider.
//   sub  : 1 -> a - b, 0 -> a + b
//   a, b : operands (W bits)
//   sum  : result, carry out of bit W-1 discarded
//   sign : sum[W-1]
// The same step also negates a value when driven with a=0, sub=1.
module nr_div_step #(
  parameter int W = 17
) (
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sign
);

  // Subtraction is addition of the one's complement plus a carry-in of one.
  assign sum  = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, sub};
  assign sign = sum[W-1];

endmodule

// File: rtl/seq_nonrestoring_div.sv
// Multi-cycle non-restoring integer divider, one quotient bit per cycle.
// One division in flight; valid/ready handshake on both sides.
//   clk, rst            : clock, synchronous active-high reset
//   inValid / inReady   : operand handshake (inReady high only in IDLE)
//   dividend, divisor   : M-bit operands
//   outValid / outReady : result handshake, result held until accepted
//   quotient, remainder : M-bit results
//   divByZero           : divisor was zero (qualified by outValid)
// Build option DIV_SIGNED_EN: two's complement operands, truncation toward
// zero, one extra SIGN state for result negation.
module seq_nonrestoring_div
  import div_pkg::*;
#(
  parameter int M = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inValid,
  output logic         inReady,
  input  logic [M-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         outValid,
  input  logic         outReady,
  output logic [M-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         divByZero
);

  localparam int CW = clog2(M);

  divState_t     state;
  logic [M:0]    rem_q;   // signed partial remainder
  logic [M-1:0]  quo_q;   // dividend shifts out the top, quotient bits in the bottom
  logic [M-1:0]  den_q;
  logic [CW-1:0] cnt;
  logic          dbz_q;

  logic [M:0]    step_a, step_b, step_sum;
  logic          step_sub, step_sign;

  assign inReady = (state == IDLE);

  // ITER: shift the next dividend bit into R, subtract if R>=0 else add.
  // FIX:  add D back when the final remainder is negative.
  always_comb begin
    step_a   = {rem_q[M-1:0], quo_q[M-1]};
    step_b   = {1'b0, den_q};
    step_sub = ~rem_q[M];
    if (state == FIX) begin
      step_a   = rem_q;
      step_sub = 1'b0;
    end
  end

  nr_div_step #(.W(M+1)) u_step (
    .sub  (step_sub),
    .a    (step_a),
    .b    (step_b),
    .sum  (step_sum),
    .sign (step_sign)
  );

`ifdef DIV_SIGNED_EN
  logic          sign_q, sign_r;
  logic [M-1:0]  neg_a_in, neg_b_in, neg_a, neg_b;
  logic          na_sign, nb_sign;
  logic          unused_neg_sign;

  // Two negators: operand magnitudes in IDLE, result sign fix-up in SIGN.
  assign neg_a_in = (state == SIGN) ? quo_q        : dividend;
  assign neg_b_in = (state == SIGN) ? rem_q[M-1:0] : divisor;

  nr_div_step #(.W(M)) u_neg_a (
    .sub (1'b1), .a ('0), .b (neg_a_in), .sum (neg_a), .sign (na_sign)
  );
  nr_div_step #(.W(M)) u_neg_b (
    .sub (1'b1), .a ('0), .b (neg_b_in), .sum (neg_b), .sign (nb_sign)
  );

  assign unused_neg_sign = na_sign ^ nb_sign;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      den_q     <= '0;
      cnt       <= '0;
      dbz_q     <= 1'b0;
      outValid  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divByZero <= 1'b0;
`ifdef DIV_SIGNED_EN
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (inValid) begin
            dbz_q <= (divisor == '0);
            cnt   <= CW'(M - 1);
            if (divisor == '0) begin
              // Raw dividend is reported as the remainder, quotient all ones.
              quo_q <= '1;
              rem_q <= {1'b0, dividend};
              state <= DONE;
            end else begin
              rem_q <= '0;
`ifdef DIV_SIGNED_EN
              quo_q  <= dividend[M-1] ? neg_a : dividend;
              den_q  <= divisor[M-1]  ? neg_b : divisor;
              sign_q <= dividend[M-1] ^ divisor[M-1];
              sign_r <= dividend[M-1];
`else
              quo_q  <= dividend;
              den_q  <= divisor;
`endif
              state <= ITER;
            end
          end
        end
        ITER: begin
          rem_q <= step_sum;
          quo_q <= {quo_q[M-2:0], ~step_sign};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          if (rem_q[M]) rem_q <= step_sum;
`ifdef DIV_SIGNED_EN
          state <= SIGN;
`else
          state <= DONE;
`endif
        end
`ifdef DIV_SIGNED_EN
        SIGN: begin
          // -2^(M-1) / -1 wraps back to -2^(M-1) naturally here.
          if (sign_q) quo_q <= neg_a;
          if (sign_r) rem_q <= {1'b0, neg_b};
          state <= DONE;
        end
`endif
        DONE: begin
          // First DONE cycle registers the result; outValid follows one edge later.
          if (!outValid) begin
            outValid  <= 1'b1;
            quotient  <= quo_q;
            remainder <= rem_q[M-1:0];
            divByZero <= dbz_q;
          end else if (outReady) begin
            outValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_nonrestoring_div.sv
module tb_seq_nonrestoring_div;

  localparam int M = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         inValid;
  logic         inReady;
  logic [M-1:0] dividend, divisor;
  logic         outValid;
  logic         outReady;
  logic [M-1:0] quotient, remainder;
  logic         divByZero;

  always #5 clk = ~clk;

  seq_nonrestoring_div #(.M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .inValid   (inValid),
    .inReady   (inReady),
    .dividend  (dividend),
    .divisor   (divisor),
    .outValid  (outValid),
    .outReady  (outReady),
    .quotient  (quotient),
    .remainder (remainder),
    .divByZero (divByZero)
  );

  typedef struct {
    logic [M-1:0] q;
    logic [M-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0;
  int   nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [M-1:0] a, input logic [M-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.dbz = 1'b0;
`ifdef DIV_SIGNED_EN
      e.lat = M + 3;
      if (a == 16'h8000 && b == 16'hFFFF) begin
        e.q = 16'h8000; e.r = '0;
      end else begin
        e.q = 16'($signed(a) / $signed(b));
        e.r = 16'($signed(a) % $signed(b));
      end
`else
      e.lat = M + 2;
      e.q = a / b;
      e.r = a % b;
`endif
    end
    return e;
  endfunction

  // Drive one division, then wait for and check its result.
  // stall: cycles outReady is held low once the result is valid.
  task automatic do_div(input logic [M-1:0] a, input logic [M-1:0] b, input int stall);
    exp_t e;
    int   k;
    sb.push_back(model(a, b));
    @(negedge clk);
    inValid  = 1'b1;
    dividend = a;
    divisor  = b;
    outReady = (stall == 0);
    @(posedge clk);                     // accept edge t
    k = 0;
    while (k < 100) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (k == 1) chk("busy_inReady", inReady, 1'b0);
      if (k == 3) inValid = 1'b0;       // repeated inValid while busy is ignored
      if (outValid) break;
    end
    e = sb.pop_front();
    if (!outValid) begin
      chk("timeout", 1'b0, 1'b1);
      inValid = 1'b0;
      return;
    end
    inValid = 1'b0;
    chk("latency",   k,         e.lat);
    chk("quotient",  quotient,  e.q);
    chk("remainder", remainder, e.r);
    chk("divByZero", divByZero, e.dbz);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", outValid, 1'b1);
      chk("stall_q",     quotient, e.q);
      chk("stall_inRdy", inReady,  1'b0);
    end
    outReady = 1'b1;
    @(negedge clk);
    chk("post_valid", outValid, 1'b0);
    chk("post_inRdy", inReady,  1'b1);
    outReady = 1'b0;
  endtask

  initial begin
    rst = 1'b1; inValid = 1'b0; outReady = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_inReady",   inReady,   1'b1);
    chk("rst_outValid",  outValid,  1'b0);
    chk("rst_quotient",  quotient,  '0);
    chk("rst_remainder", remainder, '0);
    chk("rst_dbz",       divByZero, 1'b0);
    rst = 1'b0;

    do_div(16'd100,   16'd7, 0);
    do_div(16'd65535, 16'd1, 0);
    do_div(16'd5,     16'd9, 0);
    do_div(16'd1234,  16'd0, 0);
    do_div(16'd0,     16'd5, 0);
    do_div(16'hFFFF,  16'hFFFF, 0);
    do_div(16'd100,   16'd7, 10);
`ifdef DIV_SIGNED_EN
    do_div(16'hFFF9,  16'd2,    0);
    do_div(16'd7,     16'hFFFE, 0);
    do_div(16'h8000,  16'hFFFF, 0);
`endif

    // Reset during ITER aborts the division.
    @(negedge clk);
    inValid = 1'b1; dividend = 16'd200; divisor = 16'd3;
    @(posedge clk);
    #1 inValid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_inReady",  inReady,  1'b1);
    chk("abort_outValid", outValid, 1'b0);
    chk("abort_quotient", quotient, '0);
    do_div(16'd9, 16'd3, 0);

    for (int i = 0; i < 20; i++) begin
      logic [M-1:0] a, b;
      a = M'($urandom);
      b = ($urandom_range(0, 2) == 0) ? M'($urandom_range(0, 20)) : M'($urandom);
      do_div(a, b, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
